// File: rtl/operands_dispatch_arb.sv
// Round-robin arbiter that feeds one execution-unit operand port through a registered 2-entry skid buffer.
// Optional build macro OPERANDS_ARB_PERF_EN adds perf_grants/perf_stalls counters.
module operands_dispatch_arb #(
    parameter int NUM_REQS   = 4,
    parameter int DATA_WIDTH = 512,
    parameter int IDX_W      = $clog2(NUM_REQS)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_REQS-1:0]            in_valid,
    input  logic [NUM_REQS*DATA_WIDTH-1:0] in_data,
    output logic [NUM_REQS-1:0]            in_ready,
    output logic                           out_valid,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [IDX_W-1:0]               out_idx,
    input  logic                           out_ready
`ifdef OPERANDS_ARB_PERF_EN
    ,
    output logic [31:0]                    perf_grants,
    output logic [31:0]                    perf_stalls
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQS - 1);

    buf_state_t              state_r;
    buf_state_t              state_nx_s;
    logic [IDX_W-1:0]        rr_ptr_r;
    logic [IDX_W-1:0]        winner_s;
    logic                    found_s;
    logic                    space_s;
    logic                    enq_s;
    logic                    deq_s;
    logic [NUM_REQS-1:0]     in_ready_s;
    logic [DATA_WIDTH-1:0]   win_data_s;
    logic                    out_valid_r;
    logic [DATA_WIDTH-1:0]   head_data_r;
    logic [IDX_W-1:0]        head_idx_r;
    logic [DATA_WIDTH-1:0]   tail_data_r;
    logic [IDX_W-1:0]        tail_idx_r;

    // Round-robin scan starting just after rr_ptr; first valid requester wins.
    always_comb begin : arb_scan
        int cand;
        winner_s = {IDX_W{1'b0}};
        found_s  = 1'b0;
        cand     = 0;
        for (int i = 1; i <= NUM_REQS; i++) begin
            cand = (int'(rr_ptr_r) + i) % NUM_REQS;
            if (!found_s && in_valid[cand[IDX_W-1:0]]) begin
                found_s  = 1'b1;
                winner_s = cand[IDX_W-1:0];
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Grant generation: only the winner sees ready, and only when the buffer can take it.
    always_comb begin
        in_ready_s = {NUM_REQS{1'b0}};
        space_s    = (state_r != FULL) | out_ready;
        if (reset_n && found_s) begin
            in_ready_s[winner_s] = space_s;
        end else begin
            in_ready_s = {NUM_REQS{1'b0}};
        end
    end

    assign in_ready   = in_ready_s;
    assign enq_s      = |(in_valid & in_ready_s);
    assign deq_s      = out_valid_r & out_ready;
    assign win_data_s = in_data[int'(winner_s)*DATA_WIDTH +: DATA_WIDTH];

    // Buffer occupancy next-state.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            EMPTY: begin
                if (enq_s) state_nx_s = ONE;
                else       state_nx_s = EMPTY;
            end
            ONE: begin
                if (enq_s && !deq_s)      state_nx_s = FULL;
                else if (!enq_s && deq_s) state_nx_s = EMPTY;
                else                      state_nx_s = ONE;
            end
            FULL: begin
                if (deq_s && !enq_s) state_nx_s = ONE;
                else                 state_nx_s = FULL;
            end
            default: state_nx_s = EMPTY;
        endcase
    end

    // State, pointer and skid-buffer payload registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= EMPTY;
            out_valid_r <= 1'b0;
            rr_ptr_r    <= LAST_IDX;
            head_data_r <= {DATA_WIDTH{1'b0}};
            head_idx_r  <= {IDX_W{1'b0}};
            tail_data_r <= {DATA_WIDTH{1'b0}};
            tail_idx_r  <= {IDX_W{1'b0}};
        end else begin
            state_r     <= state_nx_s;
            out_valid_r <= (state_nx_s != EMPTY);
            if (enq_s) begin
                rr_ptr_r <= winner_s;
            end
            case (state_r)
                EMPTY: begin
                    if (enq_s) begin
                        head_data_r <= win_data_s;
                        head_idx_r  <= winner_s;
                    end
                end
                ONE: begin
                    // A simultaneous dequeue empties the head slot, so the new entry lands there.
                    if (enq_s && deq_s) begin
                        head_data_r <= win_data_s;
                        head_idx_r  <= winner_s;
                    end else if (enq_s) begin
                        tail_data_r <= win_data_s;
                        tail_idx_r  <= winner_s;
                    end
                end
                FULL: begin
                    if (deq_s) begin
                        head_data_r <= tail_data_r;
                        head_idx_r  <= tail_idx_r;
                        if (enq_s) begin
                            tail_data_r <= win_data_s;
                            tail_idx_r  <= winner_s;
                        end
                    end
                end
                default: begin
                    head_data_r <= {DATA_WIDTH{1'b0}};
                    head_idx_r  <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = head_data_r;
    assign out_idx   = head_idx_r;

`ifdef OPERANDS_ARB_PERF_EN
    logic [31:0] grants_r;
    logic [31:0] stalls_r;

    // Performance counters; both wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            grants_r <= 32'd0;
            stalls_r <= 32'd0;
        end else begin
            if (deq_s) grants_r <= grants_r + 32'd1;
            if ((|in_valid) && !enq_s) stalls_r <= stalls_r + 32'd1;
        end
    end

    assign perf_grants = grants_r;
    assign perf_stalls = stalls_r;
`endif

endmodule

// File: tb/tb_operands_dispatch_arb.sv
// Directed and randomized bench for operands_dispatch_arb against a queue-based reference model.
module tb_operands_dispatch_arb;
    localparam int N  = 4;
    localparam int DW = 512;
    localparam int IW = 2;

    typedef struct {
        logic [DW-1:0] d;
        logic [IW-1:0] i;
    } ent_t;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    in_valid;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [IW-1:0]   out_idx;
    logic            out_ready;
`ifdef OPERANDS_ARB_PERF_EN
    logic [31:0]     perf_grants;
    logic [31:0]     perf_stalls;
`endif

    operands_dispatch_arb #(.NUM_REQS(N), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_ready (out_ready)
`ifdef OPERANDS_ARB_PERF_EN
        ,
        .perf_grants (perf_grants),
        .perf_stalls (perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    ent_t          q[$];
    int            rr;
    int            vectors;
    int            miscompares;
    int            last_fire;
    int            m_grants;
    int            m_stalls;
    logic          pend_v[N];
    logic [DW-1:0] pend_d[N];

    function automatic logic [DW-1:0] new_data();
        logic [DW-1:0] d;
        for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom();
        return d;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            in_valid[i]            = pend_v[i];
            in_data[i*DW +: DW]    = pend_d[i];
        end
    endtask

    function automatic int exp_winner();
        for (int j = 1; j <= N; j++) begin
            if (pend_v[(rr + j) % N]) return (rr + j) % N;
        end
        return -1;
    endfunction

    // One clock: check the combinational grant, advance the model at the edge, check registered outputs.
    task automatic cycle(input string tag);
        int          w;
        logic        space;
        logic [N-1:0] exp_ir;
        logic        rst_edge;
        ent_t        e;
        drive();
        #1;
        w      = exp_winner();
        space  = (q.size() < 2) || out_ready;
        exp_ir = '0;
        if (reset_n && w >= 0) exp_ir[w] = space;
        vectors++;
        assert (in_ready === exp_ir) else begin
            miscompares++;
            $error("FAIL %s in_ready observed=%b expected=%b", tag, in_ready, exp_ir);
        end
        last_fire = (reset_n && w >= 0 && space) ? w : -1;
        rst_edge  = !reset_n;
        @(posedge clk);
        if (rst_edge) begin
            q.delete();
            rr = N - 1;
            m_grants = 0;
            m_stalls = 0;
        end else begin
            if (out_ready && q.size() > 0) begin
                void'(q.pop_front());
                m_grants++;
            end
            if (last_fire >= 0) begin
                e.d = pend_d[last_fire];
                e.i = IW'(last_fire);
                q.push_back(e);
                rr = last_fire;
            end else if (in_valid != '0) begin
                m_stalls++;
            end
        end
        #1;
        vectors++;
        assert (out_valid === (q.size() > 0)) else begin
            miscompares++;
            $error("FAIL %s out_valid observed=%b expected=%b", tag, out_valid, q.size() > 0);
        end
        if (q.size() > 0) begin
            vectors++;
            assert (out_data === q[0].d && out_idx === q[0].i) else begin
                miscompares++;
                $error("FAIL %s head observed idx=%0d data=%h expected idx=%0d data=%h",
                       tag, out_idx, out_data[31:0], q[0].i, q[0].d[31:0]);
            end
        end else if (rst_edge) begin
            vectors++;
            assert (out_data === '0 && out_idx === '0) else begin
                miscompares++;
                $error("FAIL %s reset_out observed idx=%0d data=%h expected zero", tag, out_idx, out_data[31:0]);
            end
        end
        if (last_fire >= 0) pend_v[last_fire] = 1'b0;
    endtask

    initial begin
        vectors = 0; miscompares = 0; rr = N - 1; last_fire = -1;
        m_grants = 0; m_stalls = 0;
        for (int i = 0; i < N; i++) begin pend_v[i] = 1'b0; pend_d[i] = '0; end
        out_ready = 1'b0;
        reset_n   = 1'b0;
        drive();
        @(negedge clk);
        // reset state
        cycle("reset0");
        cycle("reset1");
        reset_n = 1'b1;
        // single request on collector 2
        out_ready = 1'b1;
        pend_v[2] = 1'b1; pend_d[2] = new_data();
        cycle("single");
        vectors++;
        assert (last_fire === 2) else begin
            miscompares++; $error("FAIL single_win observed=%0d expected=2", last_fire);
        end
        cycle("single_drain");
        // all four valid continuously, one grant per cycle in round-robin order
        reset_n = 1'b0; cycle("rst_rr"); reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < N; i++) if (!pend_v[i]) begin pend_v[i] = 1'b1; pend_d[i] = new_data(); end
            cycle("all_valid");
            vectors++;
            assert (last_fire === c % N) else begin
                miscompares++; $error("FAIL rr_order observed=%0d expected=%0d", last_fire, c % N);
            end
        end
        for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
        out_ready = 1'b1; cycle("drain"); cycle("drain");
        // collector 0 streams into a blocked output: two accepted, third held until out_ready
        reset_n = 1'b0; cycle("rst_full"); reset_n = 1'b1;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (!pend_v[0]) begin pend_v[0] = 1'b1; pend_d[0] = new_data(); end
            cycle("fill");
        end
        out_ready = 1'b1;
        cycle("skid_release");
        vectors++;
        assert (last_fire === 0) else begin
            miscompares++; $error("FAIL skid_release observed=%0d expected=0", last_fire);
        end
        // stalled winner keeps priority: rr_ptr=0, FULL, requesters 1 and 2 wait
        out_ready = 1'b0;
        pend_v[0] = 1'b1; pend_d[0] = new_data();
        cycle("refill");
        pend_v[1] = 1'b1; pend_d[1] = new_data();
        pend_v[2] = 1'b1; pend_d[2] = new_data();
        for (int c = 0; c < 3; c++) cycle("stall");
        out_ready = 1'b1;
        cycle("stall_release");
        vectors++;
        assert (last_fire === 1) else begin
            miscompares++; $error("FAIL stalled_winner observed=%0d expected=1", last_fire);
        end
        // reset with a full buffer, then the first grant goes to collector 0
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) cycle("fill2");
        reset_n = 1'b0; cycle("rst_mid"); reset_n = 1'b1;
        for (int i = 0; i < N; i++) begin pend_v[i] = 1'b1; pend_d[i] = new_data(); end
        out_ready = 1'b1;
        cycle("post_reset");
        vectors++;
        assert (last_fire === 0) else begin
            miscompares++; $error("FAIL post_reset_grant observed=%0d expected=0", last_fire);
        end
        // randomized traffic with random backpressure
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if (!pend_v[i] && $urandom_range(0, 2) == 0) begin pend_v[i] = 1'b1; pend_d[i] = new_data(); end
            out_ready = ($urandom_range(0, 3) != 0);
            cycle("random");
        end
`ifdef OPERANDS_ARB_PERF_EN
        vectors++;
        assert (perf_grants === 32'(m_grants) && perf_stalls === 32'(m_stalls)) else begin
            miscompares++;
            $error("FAIL perf observed g=%0d s=%0d expected g=%0d s=%0d", perf_grants, perf_stalls, m_grants, m_stalls);
        end
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
